// File: rtl/avalon_arbiter_n.sv
// N-master Avalon-MM burst arbiter: round-robin grants, locked write bursts, tagged read returns.
// Optional AVALON_ARBITER_PRIORITY_EN adds ipHighPriority to restrict arbitration to a subset.
module avalon_arbiter_n #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 27,
  parameter int BURST_WIDTH = 8,
  parameter int READ_DEPTH  = 16
) (
  input  logic                                ipClk,
  input  logic                                ipReset,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   ipMaster_Address,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] ipMaster_ByteEnable,
  input  logic [NUM_MASTERS*BURST_WIDTH-1:0]  ipMaster_BurstCount,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   ipMaster_WriteData,
  input  logic [NUM_MASTERS-1:0]              ipMaster_Write,
  input  logic [NUM_MASTERS-1:0]              ipMaster_Read,
`ifdef AVALON_ARBITER_PRIORITY_EN
  input  logic [NUM_MASTERS-1:0]              ipHighPriority,
`endif
  output logic [NUM_MASTERS-1:0]              opMaster_WaitRequest,
  output logic [DATA_WIDTH-1:0]               opMaster_ReadData,
  output logic [NUM_MASTERS-1:0]              opMaster_ReadValid,
  input  logic                                ipAvalon_WaitRequest,
  output logic [ADDR_WIDTH-1:0]               opAvalon_Address,
  output logic [DATA_WIDTH/8-1:0]             opAvalon_ByteEnable,
  output logic [BURST_WIDTH-1:0]              opAvalon_BurstCount,
  output logic [DATA_WIDTH-1:0]               opAvalon_WriteData,
  output logic                                opAvalon_Write,
  output logic                                opAvalon_Read,
  input  logic [DATA_WIDTH-1:0]               ipAvalon_ReadData,
  input  logic                                ipAvalon_ReadValid
);

  localparam int MW  = $clog2(NUM_MASTERS);
  localparam int BEW = DATA_WIDTH / 8;
  localparam int PW  = $clog2(READ_DEPTH);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, stateNxt;
  logic [MW-1:0] grant, grantNxt;
  logic [MW-1:0] lastGrant, lastGrantNxt;
  logic [BURST_WIDTH-1:0] beatCnt, beatCntNxt;
  logic inBurst, inBurstNxt;

  logic [ADDR_WIDTH-1:0]  mAddr  [NUM_MASTERS];
  logic [BEW-1:0]         mBe    [NUM_MASTERS];
  logic [BURST_WIDTH-1:0] mBurst [NUM_MASTERS];
  logic [DATA_WIDTH-1:0]  mData  [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] reqVec;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : gUnpack
    assign mAddr[i]  = ipMaster_Address[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign mBe[i]    = ipMaster_ByteEnable[i*BEW +: BEW];
    assign mBurst[i] = ipMaster_BurstCount[i*BURST_WIDTH +: BURST_WIDTH];
    assign mData[i]  = ipMaster_WriteData[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign reqVec = ipMaster_Read | ipMaster_Write;

  // Round-robin search starting just after the last completed grant.
  logic [NUM_MASTERS-1:0] candMask;
  logic [MW-1:0] arbPick;
  logic [MW-1:0] cand;
  logic arbValid;
  int arbIdx;

  always_comb begin
    candMask = reqVec;
`ifdef AVALON_ARBITER_PRIORITY_EN
    if (|(reqVec & ipHighPriority))
      candMask = reqVec & ipHighPriority;
`endif
    arbPick  = '0;
    arbValid = 1'b0;
    arbIdx   = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      arbIdx = (int'(lastGrant) + k) % NUM_MASTERS;
      cand   = MW'(arbIdx);
      if (!arbValid && candMask[cand]) begin
        arbPick  = cand;
        arbValid = 1'b1;
      end
    end
  end

  // Tag FIFO of outstanding read bursts
  logic [MW-1:0]          tagMaster [READ_DEPTH];
  logic [BURST_WIDTH-1:0] tagBurst  [READ_DEPTH];
  logic [PW:0] wrPtr, rdPtr;
  logic fifoEmpty, fifoFull;
  logic tagPush, tagPop;

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PW] != rdPtr[PW]) &&
                     (wrPtr[PW-1:0] == rdPtr[PW-1:0]);

  logic [BURST_WIDTH-1:0] burstEff;
  logic readBlocked, wrAcc, rdAcc;

  assign burstEff = (mBurst[grant] == '0) ? BURST_WIDTH'(1)
                                          : mBurst[grant];

  always_comb begin
    opAvalon_Address     = '0;
    opAvalon_ByteEnable  = '0;
    opAvalon_BurstCount  = '0;
    opAvalon_WriteData   = '0;
    opAvalon_Write       = 1'b0;
    opAvalon_Read        = 1'b0;
    opMaster_WaitRequest = '1;
    readBlocked          = 1'b0;
    wrAcc                = 1'b0;
    rdAcc                = 1'b0;
    if (state == ACTIVE) begin
      opAvalon_Address    = mAddr[grant];
      opAvalon_ByteEnable = mBe[grant];
      opAvalon_BurstCount = mBurst[grant];
      opAvalon_WriteData  = mData[grant];
      opAvalon_Write      = ipMaster_Write[grant];
      readBlocked = ipMaster_Read[grant] & ~ipMaster_Write[grant] &
                    ~inBurst & fifoFull;
      opAvalon_Read = ipMaster_Read[grant] & ~ipMaster_Write[grant] &
                      ~inBurst & ~fifoFull;
      opMaster_WaitRequest[grant] = ipAvalon_WaitRequest | readBlocked;
      wrAcc = opAvalon_Write & ~ipAvalon_WaitRequest;
      rdAcc = opAvalon_Read & ~ipAvalon_WaitRequest;
    end
  end

  always_comb begin
    stateNxt     = state;
    grantNxt     = grant;
    lastGrantNxt = lastGrant;
    beatCntNxt   = beatCnt;
    inBurstNxt   = inBurst;
    tagPush      = 1'b0;
    unique case (state)
      IDLE: begin
        if (arbValid) begin
          grantNxt = arbPick;
          stateNxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (inBurst) begin
          if (wrAcc) begin
            beatCntNxt = beatCnt - BURST_WIDTH'(1);
            if (beatCnt == BURST_WIDTH'(1)) begin
              stateNxt     = IDLE;
              inBurstNxt   = 1'b0;
              lastGrantNxt = grant;
            end
          end
        end else if (!reqVec[grant]) begin
          stateNxt = IDLE;
        end else if (wrAcc) begin
          beatCntNxt = burstEff - BURST_WIDTH'(1);
          if (burstEff == BURST_WIDTH'(1)) begin
            stateNxt     = IDLE;
            lastGrantNxt = grant;
          end else begin
            inBurstNxt = 1'b1;
          end
        end else if (rdAcc) begin
          tagPush      = 1'b1;
          lastGrantNxt = grant;
          stateNxt     = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  // Read return path is purely combinational from the slave
  logic [MW-1:0] headMaster;
  logic [BURST_WIDTH-1:0] headBurst;
  logic [BURST_WIDTH-1:0] retCnt;
  logic retValid;

  assign headMaster = tagMaster[rdPtr[PW-1:0]];
  assign headBurst  = tagBurst[rdPtr[PW-1:0]];
  assign retValid   = ipAvalon_ReadValid & ~fifoEmpty;
  assign tagPop     = retValid &&
                      (retCnt == headBurst - BURST_WIDTH'(1));

  assign opMaster_ReadData  = ipAvalon_ReadData;
  assign opMaster_ReadValid = retValid ?
    (NUM_MASTERS'(1) << headMaster) : '0;

  always_ff @(posedge ipClk) begin
    if (tagPush) begin
      tagMaster[wrPtr[PW-1:0]] <= grant;
      tagBurst[wrPtr[PW-1:0]]  <= burstEff;
    end
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state     <= IDLE;
      grant     <= '0;
      lastGrant <= MW'(NUM_MASTERS - 1);
      beatCnt   <= '0;
      inBurst   <= 1'b0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      retCnt    <= '0;
    end else begin
      state     <= stateNxt;
      grant     <= grantNxt;
      lastGrant <= lastGrantNxt;
      beatCnt   <= beatCntNxt;
      inBurst   <= inBurstNxt;
      wrPtr     <= wrPtr + (PW+1)'(tagPush);
      rdPtr     <= rdPtr + (PW+1)'(tagPop);
      if (tagPop)
        retCnt <= '0;
      else if (retValid)
        retCnt <= retCnt + BURST_WIDTH'(1);
    end
  end

endmodule

// File: doc/avalon_arbiter_n.md
# avalon_arbiter_n

Parametrised N-master Avalon-MM burst arbiter; the successor of the two-master SDRAM arbiter in the radar processor. It shares one pipelined, burst-capable SDRAM port among NUM_MASTERS clients (corner turn, alpha filter, capture DMA, debug reader, and others). Grants are round-robin, write bursts are locked, and up to READ_DEPTH outstanding read bursts are tracked so read data returns to the correct master.

## Interface
- NUM_MASTERS, 4: number of masters (2..8).
- DATA_WIDTH, 256: data bus width; byte-enable width is DATA_WIDTH/8.
- ADDR_WIDTH, 27: word address width.
- BURST_WIDTH, 8: burst-count width.
- READ_DEPTH, 16: outstanding read-burst tag FIFO depth (power of 2).

- ipClk  in  1  clock; all logic is on the rising edge.
- ipReset  in  1  synchronous, active-high reset.
- ipMaster_Address  in  N*ADDR_WIDTH  master i at slice i.
- ipMaster_ByteEnable  in  N*DATA_WIDTH/8  per-master byte enables.
- ipMaster_BurstCount  in  N*BURST_WIDTH  per-master burst length.
- ipMaster_WriteData  in  N*DATA_WIDTH  per-master write data.
- ipMaster_Write, ipMaster_Read  in  N each  per-master command strobes.
- opMaster_WaitRequest  out  N  per-master stall.
- opMaster_ReadData  out  DATA_WIDTH  broadcast to all masters.
- opMaster_ReadValid  out  N  one-hot owner of the current read beat.
- ipAvalon_WaitRequest  in  1  slave stall.
- opAvalon_Address/ByteEnable/BurstCount/WriteData  out  widths as above  slave command.
- opAvalon_Write, opAvalon_Read  out  1 each  slave strobes.
- ipAvalon_ReadData  in  DATA_WIDTH  read data from the slave.
- ipAvalon_ReadValid  in  1  read data valid.

## Operation
- Request vector: req[i] = Read[i] | Write[i].
- Command FSM, IDLE:
  - All master waitrequests are 1.
  - Avalon strobes and command fields are driven to 0.
  - If any req is set, grant the first requester after LastGrant (circular search), register Grant, and go to ACTIVE.
- Command FSM, ACTIVE:
  - Avalon command fields and strobes are muxed combinationally from master Grant.
  - opMaster_WaitRequest[Grant] = ipAvalon_WaitRequest; all other waitrequests are 1.
- Read in ACTIVE:
  - If the tag FIFO is full, gate opAvalon_Read to 0 and hold WaitRequest[Grant] at 1.
  - Otherwise, on an accepted read (Read & !ipAvalon_WaitRequest), push {Grant, BurstCount} to the tag FIFO, set LastGrant=Grant, and go to IDLE.
- Write in ACTIVE:
  - On the first accepted beat, load BeatCnt = BurstCount-1; if the result is 0, go to IDLE.
  - On each later accepted beat, decrement BeatCnt; when it reaches 0, set LastGrant and go to IDLE.
  - The burst is locked: Grant does not change until the last beat.
- Abandon: if req[Grant] drops in ACTIVE before the first accepted beat, go to IDLE without changing LastGrant.
- BurstCount 0 is treated as 1.
- Read return path:
  - opMaster_ReadData = ipAvalon_ReadData.
  - opMaster_ReadValid = ipAvalon_ReadValid ? onehot(head.master) : 0.
  - RetCnt counts beats; the tag is popped on the last beat of its burst.
  - A push and a pop in the same cycle are both honoured.
- ReadValid with an empty tag FIFO is a protocol error: the beat is dropped and ReadValid stays 0.

## Timing
- Reset values:
  - FSM = IDLE; Grant = 0; LastGrant = NUM_MASTERS-1, so master 0 wins first.
  - Tag FIFO is empty; BeatCnt = RetCnt = 0.
  - All opMaster_WaitRequest = 1; opMaster_ReadValid = 0.
  - All opAvalon_* = 0.
- Arbitration latency is 1 cycle: a request in IDLE at cycle t is presented to the slave at t+1.
- Minimum 2 cycles per single-beat command (IDLE bubble); a write burst of B beats takes at least B+1 cycles.
- Read return path is combinational: zero added latency from slave to master.
- Reset mid-burst aborts the write burst and flushes all read tags. The slave must be reset together with the arbiter.
- Masters must hold their command stable while WaitRequest=1 (Avalon rule). The arbiter does not register it.

## Configuration
- AVALON_ARBITER_PRIORITY_EN defined:
  - Adds port ipHighPriority  in  NUM_MASTERS.
  - In IDLE, if any req&ipHighPriority is set, round-robin runs over that subset only; otherwise it runs over all requesters.
  - Write bursts stay locked regardless of priority.
- Undefined: the port is absent and arbitration is plain round-robin.

## Test plan
- Reset, then masters 0..3 all request single-beat reads → grants follow the order 0,1,2,3,0. ReadValid one-hot follows the same order as the slave returns data with 3-cycle latency.
- Master 1 writes burst of 8 while master 2 requests continuously → exactly 8 beats from master 1 on the Avalon bus, with no master-2 beat in between. Master 2 is granted on the following cycle after IDLE.
- Slave holds WaitRequest=1 for 5 cycles mid-write → BeatCnt frozen, Address/WriteData stable, burst completes with 8 beats total.
- 17 single-beat reads issued with slave ReadValid withheld (READ_DEPTH=16) → 16 accepted, 17th held with WaitRequest=1 and opAvalon_Read=0. Returning one beat releases it.
- Master 3 reads burst 4, then master 0 reads burst 2 → 4 beats with ReadValid=4'b1000, then 2 beats with ReadValid=4'b0001.
- With AVALON_ARBITER_PRIORITY_EN, ipHighPriority=4'b0100, masters 0 and 2 requesting → master 2 is granted 3 consecutive times while it keeps requesting. With master 2 idle, master 0 is granted.
